// File: rtl/shared_data_mem_rr_pkg.sv
// mem_pkg: shared defaults, width helper and access-type encoding for the shared data memory
package mem_pkg;
  localparam int DEF_REG_WIDTH = 12;
  localparam int DEF_DATA_MEM_DEPTH = 4096;
  localparam logic ACC_RD = 1'b0;
  localparam logic ACC_WR = 1'b1;
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/shared_data_mem_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or after ptr
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = addr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  localparam logic [2*N-1:0] ONE = (2*N)'(1);
  logic [2*N-1:0] dbl, msk, lsb;
  // lower copy is masked below ptr, upper copy supplies the wrap-around
  always_comb begin
    dbl = {req, req};
    msk = dbl & ~((ONE << ptr) - ONE);
    lsb = msk & (~msk + ONE);
    gnt = lsb[N-1:0] | lsb[2*N-1:N];
  end
endmodule

// File: rtl/shared_data_mem_rr.sv
// shared_data_mem_rr: single-port data memory shared by N_CORES round-robin ports
// plus a top-priority host port; one access per cycle, registered read data.
module shared_data_mem_rr
  import mem_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH,
  parameter int N_CORES = 4,
  localparam int ADDR_WIDTH = addr_width(DATA_MEM_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            hostEn,
  input  logic                            hostWrEn,
  input  logic [ADDR_WIDTH-1:0]           hostAddr,
  input  logic [REG_WIDTH-1:0]            hostDataIn,
  output logic                            hostValid,
  input  logic [N_CORES-1:0]              coreReq,
  input  logic [N_CORES-1:0]              coreWrEn,
  input  logic [N_CORES*ADDR_WIDTH-1:0]   coreAddr,
  input  logic [N_CORES*REG_WIDTH-1:0]    coreDataIn,
  output logic [N_CORES-1:0]              coreGnt,
  output logic [N_CORES-1:0]              coreValid,
  output logic [REG_WIDTH-1:0]            dataOut
);
  localparam int PW = addr_width(N_CORES);
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DATA_MEM_DEPTH);
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [N_CORES-1:0] arb_gnt, core_valid_q, core_valid_d;
  logic host_valid_q, host_valid_d;
  logic [REG_WIDTH-1:0] data_out_q, data_out_d, acc_data;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic acc_en, acc_wr, in_range;
  logic [REG_WIDTH-1:0] mem [DATA_MEM_DEPTH];

  rr_arbiter #(.N(N_CORES)) u_arb (.req(coreReq), .ptr(rr_ptr_q), .gnt(arb_gnt));

  assign coreGnt = hostEn ? '0 : arb_gnt;
  assign coreValid = core_valid_q;
  assign hostValid = host_valid_q;
  assign dataOut = data_out_q;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CORES; i++) if (arb_gnt[i]) gnt_idx = PW'(i);
    acc_en = hostEn | (|arb_gnt);
    acc_wr = hostEn ? hostWrEn : coreWrEn[gnt_idx];
    acc_addr = hostEn ? hostAddr : coreAddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    acc_data = hostEn ? hostDataIn : coreDataIn[gnt_idx*REG_WIDTH +: REG_WIDTH];
    in_range = {1'b0, acc_addr} < DEPTH_V;
    host_valid_d = hostEn & (hostWrEn == ACC_RD);
    core_valid_d = coreGnt & ~coreWrEn;
    data_out_d = (acc_en && acc_wr == ACC_RD) ? (in_range ? mem[acc_addr] : '0) : data_out_q;
    rr_ptr_d = (|coreGnt) ? ((gnt_idx == PW'(N_CORES-1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr_q <= '0;
      core_valid_q <= '0;
      host_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      core_valid_q <= core_valid_d;
      host_valid_q <= host_valid_d;
      data_out_q <= data_out_d;
    end
  end

  // array is never cleared; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (rstN && acc_en && acc_wr == ACC_WR && in_range) mem[acc_addr] <= acc_data;
  end
endmodule
